// File: rtl/em_pickup_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : em_pickup_sequencer
// Purpose  : Electromagnet pick-up / carry / release sequencer with pull-in
//            retries, PWM hold, lost-block detection and optional demag pulse
//            (build macro EM_DEMAG_EN enables the reverse demagnetising pulse).
// Revision : 1.0 - initial release
// ============================================================================
module em_pickup_sequencer #(
    parameter logic [31:0] PICKUP_MASK = 32'h00C0_0C00,
    parameter logic [31:0] DROP_MASK   = 32'hFF3F_F3FF,
    parameter int          PULLIN_CYC  = 50000,
    parameter int          HOLD_DUTY   = 10,
    parameter int          LOSS_CYC    = 25000,
    parameter int          DEMAG_CYC   = 5000,
    parameter int          RETRY_MAX   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] node,
    input  logic       pickup_req,
    input  logic       drop_req,
    input  logic       block_det,
    input  logic       fault_clr,
    output logic       o1,
    output logic       o2,
    output logic       holding,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PULLIN  = 3'd1;
    localparam logic [2:0] S_GAP     = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;
`ifdef EM_DEMAG_EN
    localparam logic [2:0] S_DEMAG   = 3'd6;
`endif

    localparam logic [15:0] c_PULLIN_LAST = 16'(PULLIN_CYC - 1);
    localparam logic [15:0] c_LOSS_LAST   = 16'(LOSS_CYC - 1);
    localparam logic [15:0] c_DEMAG_LAST  = 16'(DEMAG_CYC - 1);
    localparam logic [4:0]  c_HOLD_DUTY   = 5'(HOLD_DUTY);
    localparam logic [1:0]  c_RETRY_LAST  = 2'(RETRY_MAX - 1);

    logic [2:0]  r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt, w_cnt_end;
    logic [3:0]  r_pwm, w_pwm_nxt;
    logic [1:0]  r_retry, w_retry_nxt;
    logic        w_cnt_at_end, w_pick_ok, w_drop_ok, w_done_nxt, w_o1_nxt;
    logic        r_o1, r_holding, r_busy, r_done, r_fault;

    assign w_pick_ok    = pickup_req && PICKUP_MASK[node];
    assign w_drop_ok    = drop_req && DROP_MASK[node];
    assign w_cnt_at_end = (r_cnt == w_cnt_end);

    // One shared counter: pull-in timer, loss run length, or demag timer.
    always_comb begin
        case (r_state)
            S_HOLD:   w_cnt_end = c_LOSS_LAST;
            S_PULLIN: w_cnt_end = c_PULLIN_LAST;
            default:  w_cnt_end = c_DEMAG_LAST;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 16'd1;
        w_pwm_nxt   = r_pwm + 4'd1;
        w_retry_nxt = r_retry;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_ok) begin
                    w_state_nxt = S_PULLIN;
                    w_retry_nxt = 2'd0;
                end
            end
            S_PULLIN: begin
                if (w_cnt_at_end) begin
                    if (block_det) begin
                        w_state_nxt = S_HOLD;
                    end else if (r_retry < c_RETRY_LAST) begin
                        w_state_nxt = S_GAP;
                        w_retry_nxt = r_retry + 2'd1;
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end
            end
            S_GAP: w_state_nxt = S_PULLIN;
            S_HOLD: begin
                if (w_drop_ok) begin
                    w_state_nxt = S_RELEASE;
                end else if (!block_det) begin
                    if (w_cnt_at_end) begin
                        w_state_nxt = S_FAULT;
                    end
                end else begin
                    w_cnt_nxt = 16'd0;
                end
            end
`ifdef EM_DEMAG_EN
            S_RELEASE: w_state_nxt = S_DEMAG;
            S_DEMAG: begin
                if (w_cnt_at_end) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`else
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
`endif
            S_FAULT: begin
                if (fault_clr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = 16'd0;
            w_pwm_nxt = 4'd0;
        end
    end

    // Outputs are registered from the next state so they change on the edge
    // that makes the decision.
    assign w_o1_nxt = (w_state_nxt == S_PULLIN) ||
                      ((w_state_nxt == S_HOLD) && ({1'b0, w_pwm_nxt} < c_HOLD_DUTY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_pwm     <= 4'd0;
            r_retry   <= 2'd0;
            r_o1      <= 1'b0;
            r_holding <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pwm     <= w_pwm_nxt;
            r_retry   <= w_retry_nxt;
            r_o1      <= w_o1_nxt;
            r_holding <= (w_state_nxt == S_HOLD);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_fault   <= (w_state_nxt == S_FAULT);
        end
    end

`ifdef EM_DEMAG_EN
    logic r_o2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o2 <= 1'b0;
        end else begin
            r_o2 <= (w_state_nxt == S_DEMAG);
        end
    end
    assign o2 = r_o2;
`else
    assign o2 = 1'b0;
`endif

    assign o1      = r_o1;
    assign holding = r_holding;
    assign busy    = r_busy;
    assign done    = r_done;
    assign fault   = r_fault;

endmodule
`default_nettype wire

// File: doc/em_pickup_sequencer.md
# em_pickup_sequencer

Sequences the rover's electromagnet through a full pick-up / carry / release cycle. It sits between the path planner, which supplies the current node and pickup/drop requests, and the electromagnet H-bridge inputs `o1`/`o2`. The block verifies the pick-up against the ultrasonic block-detect signal and reduces coil drive with PWM while carrying. It also detects a lost block and can optionally apply a reverse demagnetising pulse on release.

## Interface
Parameters:
- `PICKUP_MASK`, 32'h00C0_0C00: bit n set means node n is a valid pick-up node (default nodes 10, 11, 22, 23).
- `DROP_MASK`, 32'hFF3F_F3FF: bit n set means node n is a valid drop node.
- `PULLIN_CYC`, 50000: full-drive pull-in duration, in cycles (1..65535).
- `HOLD_DUTY`, 10: hold PWM high count out of a fixed period of 16 (0..16).
- `LOSS_CYC`, 25000: consecutive cycles of `block_det`=0 in HOLD that declare a lost block.
- `DEMAG_CYC`, 5000: reverse-pulse duration, in cycles (1..65535).
- `RETRY_MAX`, 2: pull-in attempts before FAULT (1..3).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `node`, in, 5: current/next node index from the planner.
- `pickup_req`, in, 1: one-cycle request to pick up.
- `drop_req`, in, 1: one-cycle request to release.
- `block_det`, in, 1: ultrasonic "block attached" signal, already synchronised.
- `fault_clr`, in, 1: one-cycle pulse that clears FAULT.
- `o1`, out, 1: H-bridge forward drive (magnetise).
- `o2`, out, 1: H-bridge reverse drive (demagnetise).
- `holding`, out, 1: high while in HOLD.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when a release completes.
- `fault`, out, 1: high while in FAULT.

## Operation
- All outputs are registered. Reset value of every output is 0, and the state register resets to IDLE. Reset asserted mid-operation de-energises the coil immediately.
- Invariant: `o1` and `o2` are never high in the same cycle.
- IDLE: `o1`=`o2`=0.
  - `pickup_req` with `PICKUP_MASK[node]`=1: clear the retry counter and go to PULLIN.
  - A request at a node not in the mask is ignored.
  - `drop_req` in IDLE is ignored.
- PULLIN: `o1`=1 for exactly `PULLIN_CYC` cycles, after which `block_det` is sampled.
  - Sample = 1: go to HOLD.
  - Sample = 0 and retries+1 < `RETRY_MAX`: increment retries, spend one cycle in IDLE-equivalent GAP with `o1`=0, then re-enter PULLIN.
  - Otherwise: go to FAULT.
- HOLD: a 4-bit PWM counter free-runs from 0 on entry. `o1` = (pwm_cnt < `HOLD_DUTY`).
  - `drop_req` with `DROP_MASK[node]`=1: go to RELEASE. A drop request at any other node is ignored.
  - The loss counter counts consecutive `block_det`=0 cycles and resets on any `block_det`=1. Reaching `LOSS_CYC`: go to FAULT.
- RELEASE: one dead cycle with `o1`=`o2`=0, then DEMAG (see Configuration).
- DEMAG: `o2`=1 for `DEMAG_CYC` cycles, then IDLE with `done` pulsed for 1 cycle.
- FAULT: `o1`=`o2`=0 and `fault`=1. `fault_clr` returns the block to IDLE. Requests in FAULT are ignored.
- Simultaneous events:
  - `pickup_req` and `drop_req` together in IDLE: pickup wins.
  - `drop_req` and loss timeout in the same HOLD cycle: drop wins.
  - `fault_clr` outside FAULT has no effect.
- Counters are 16-bit, saturate-free, and clear on every state entry.

## Timing
- `pickup_req` sampled high at edge N: `o1`=1 and `busy`=1 from edge N (visible in cycle N+1).
- `o1` falls or goes PWM at edge N+`PULLIN_CYC`. `block_det` is sampled on the last PULLIN cycle.
- A failed attempt costs `PULLIN_CYC`+1 cycles.
- `drop_req` at edge M: `o1`=0 from M. `o2`=1 from M+1 through M+`DEMAG_CYC`. `done`=1 and `busy`=0 at M+`DEMAG_CYC`+1.
- Loss detection fires on the `LOSS_CYC`-th consecutive low sample. `fault` and `o1`=0 appear on the same edge.

## Configuration
- `EM_DEMAG_EN` defined: RELEASE proceeds to DEMAG as described.
- `EM_DEMAG_EN` not defined: the DEMAG state is not built and `o2` is tied to 0.
  - RELEASE returns to IDLE after its dead cycle, with `done` pulsed on that edge.
  - Release latency is 2 cycles from `drop_req`.

## Test plan
- Pickup success (`PULLIN_CYC`=8): `node`=10, `pickup_req` pulse, `block_det`=1. Expect `o1`=1 for 8 cycles, then `holding`=1 and `o1` PWM with 10 high / 6 low per 16 cycles.
- Invalid node: `node`=5 with `pickup_req`. Expect `busy`, `o1` and `o2` to stay 0.
- Retry exhaustion (`RETRY_MAX`=2): `block_det`=0 throughout. Expect two 8-cycle `o1` bursts separated by 1 low cycle, then `fault`=1. `fault_clr` then returns `busy` to 0.
- Release (`DEMAG_CYC`=4, macro defined): from HOLD, `node`=3 with `drop_req`. Expect 1 dead cycle, `o2`=1 for 4 cycles, then `done` pulse. `o1`&`o2` never both 1. With the macro undefined: `done` at cycle 2 and `o2` always 0.
- Lost block (`LOSS_CYC`=6): in HOLD, drop `block_det` for 5 cycles then raise it, expect no fault. Then drop it for 6 cycles, expect `fault`=1 and `o1`=0.
- Reset mid-PULLIN: assert `rst` asynchronously between edges. Expect `o1` to go 0 immediately, `busy` to go 0, and the block to be in IDLE after release.
